// File: rtl/multi_channel_input_filter_pkg.sv
// Shared constants for the multi-channel input filter: default widths, default
// stability length and the minimum length substituted for a zero load.
package multi_channel_input_filter_pkg;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_GLITCH_W = 8;
  localparam int DEF_LEN      = 100;
  localparam int MIN_LEN      = 1;
endpackage

// File: rtl/multi_channel_input_filter_if.sv
// Pin/register-side bundle of the input filter; the filter core uses the slave view.
interface multi_channel_input_filter_if
  import multi_channel_input_filter_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int GLITCH_W = DEF_GLITCH_W
);
  logic [NUM_CH-1:0]          noisy_in;
  logic [CNT_W-1:0]           filter_len_in;
  logic                       load_filter_len;
  logic                       glitch_clr;
  logic [NUM_CH-1:0]          filtered_out;
  logic [NUM_CH-1:0]          filtered_out_n;
  logic [NUM_CH-1:0]          rise_pulse;
  logic [NUM_CH-1:0]          fall_pulse;
  logic [NUM_CH*GLITCH_W-1:0] glitch_cnt;
  logic [CNT_W-1:0]           filter_len_q;

  modport master (
    output noisy_in, filter_len_in, load_filter_len, glitch_clr,
    input  filtered_out, filtered_out_n, rise_pulse, fall_pulse, glitch_cnt, filter_len_q
  );

  modport slave (
    input  noisy_in, filter_len_in, load_filter_len, glitch_clr,
    output filtered_out, filtered_out_n, rise_pulse, fall_pulse, glitch_cnt, filter_len_q
  );
endinterface

// File: rtl/multi_channel_input_filter_channel_core.sv
// One filter lane: 2-FF synchroniser, stability counter, debounced level with
// registered edge pulses, and a saturating glitch counter.
module multi_channel_input_filter_channel_core #(
  parameter int   CNT_W     = 16,
  parameter int   GLITCH_W  = 8,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                noisy,
  input  logic [CNT_W-1:0]    len,
  input  logic                glitch_clr,
  output logic                filtered,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);
  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_nxt;
  logic             glitch;

  // One extra bit so the compare stays correct when len sits at its maximum.
  assign cnt_nxt = {1'b0, cnt} + (CNT_W+1)'(1);
  assign glitch  = (sync2 == filtered) && (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= RESET_VAL;
      sync2      <= RESET_VAL;
      filtered   <= RESET_VAL;
      cnt        <= '0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      sync1 <= noisy;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == filtered) begin
        cnt <= '0;
      end else if (cnt_nxt >= {1'b0, len}) begin
        // >= rather than == so a length lowered below cnt still flips at once.
        filtered <= ~filtered;
        cnt      <= '0;
        rise     <= ~filtered;
        fall     <= filtered;
      end else begin
        cnt <= cnt_nxt[CNT_W-1:0];
      end
      if (glitch_clr)
        glitch_cnt <= '0;
      else if (glitch && (glitch_cnt != '1))
        glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end
endmodule

// File: rtl/multi_channel_input_filter.sv
// NUM_CH-lane debounce filter; owns the runtime stability length shared by all lanes.
module multi_channel_input_filter
  import multi_channel_input_filter_pkg::*;
#(
  parameter int                NUM_CH      = 3,
  parameter int                CNT_W       = DEF_CNT_W,
  parameter int                GLITCH_W    = DEF_GLITCH_W,
  parameter logic [NUM_CH-1:0] RESET_VAL   = '0,
  parameter logic [CNT_W-1:0]  DEFAULT_LEN = CNT_W'(DEF_LEN)
) (
  input logic                         clk,
  input logic                         reset,
  multi_channel_input_filter_if.slave bus
);
  logic [CNT_W-1:0]                   len_q;
  logic [NUM_CH-1:0]                  filt, rise, fall;
  logic [NUM_CH-1:0][GLITCH_W-1:0]    gcnt;

  // A zero length would never satisfy the compare sensibly; store the minimum instead.
  always_ff @(posedge clk) begin
    if (reset)
      len_q <= DEFAULT_LEN;
    else if (bus.load_filter_len)
      len_q <= (bus.filter_len_in == '0) ? CNT_W'(MIN_LEN) : bus.filter_len_in;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_channel_input_filter_channel_core #(
      .CNT_W     (CNT_W),
      .GLITCH_W  (GLITCH_W),
      .RESET_VAL (RESET_VAL[i])
    ) u_core (
      .clk        (clk),
      .reset      (reset),
      .noisy      (bus.noisy_in[i]),
      .len        (len_q),
      .glitch_clr (bus.glitch_clr),
      .filtered   (filt[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .glitch_cnt (gcnt[i])
    );
  end

  assign bus.filtered_out   = filt;
  assign bus.filtered_out_n = ~filt;
  assign bus.rise_pulse     = rise;
  assign bus.fall_pulse     = fall;
  assign bus.glitch_cnt     = gcnt;
  assign bus.filter_len_q   = len_q;
endmodule
